mem_access_stage: RTL and testbench

Fourth pipeline stage of the MIPS core: it sits directly downstream of the execution stage and consumes its ALU result, store operand and destination register. It contains the EX/MEM pipeline register, a load/store handshake FSM towards data memory with byte/halfword/word alignment, and the MEM/WB output register feeding write-back. It stalls the pipeline while a memory access is outstanding.

---
 rtl/mips_pkg.sv | 13 +
 rtl/load_align.sv | 31 +++
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared memory-size encodings and MEM-stage FSM states
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select with sign/zero extension
module load_align
  import mips_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (offset)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SIZE_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: EX/MEM reg, load/store FSM, MEM/WB reg
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being aligned.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [31:0]       aluResult,
  input  logic [31:0]       reg2Out,
  input  logic [4:0]        muxRegDstOut,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        memSize,
  input  logic              memSigned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [31:0]       wbData,
  output logic [31:0]       aluResultOut,
  output logic [31:0]       readDataOut,
  output logic [4:0]        writeRegOut,
  output logic              regWriteOut,
  output logic              memToRegOut,
  output logic              excMisaligned
);

  logic [31:0] alu_q, st_q;
  logic [4:0]  wreg_q;
  logic        regwrite_q, memtoreg_q, memread_q, memwrite_q, signed_q;
  logic [1:0]  size_q;

  mem_state_e  state, state_nx;
  logic [1:0]  off;
  logic        misaligned, trap, mem_op;
  logic [3:0]  be;
  logic [31:0] wdata, load_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q      <= '0;
      st_q       <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
    end else if (!stall) begin
      alu_q      <= aluResult;
      st_q       <= reg2Out;
      wreg_q     <= muxRegDstOut;
      memtoreg_q <= memToReg;
      size_q     <= memSize;
      signed_q   <= memSigned;
      regwrite_q <= regWrite & ~flush;
      memread_q  <= memRead & ~flush;
      memwrite_q <= memWrite & ~flush;
    end
  end

  // Naturally aligned lane offset; a mismatch with the raw bits means misalignment.
  always_comb begin
    case (size_q)
      SIZE_BYTE: off = alu_q[1:0];
      SIZE_HALF: off = {alu_q[1], 1'b0};
      default:   off = 2'b00;
    endcase
    misaligned = (off != alu_q[1:0]);
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (memread_q | memwrite_q) & misaligned;
`else
  assign trap = 1'b0;
`endif

  assign mem_op = (memread_q | memwrite_q) & ~trap;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    mem_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_req = mem_op;
        if (mem_op && !mem_ack) begin
          stall    = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_req = 1'b1;
        stall   = ~mem_ack;
        if (mem_ack) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = st_q;
    case (size_q)
      SIZE_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{st_q[7:0]}};
      end
      SIZE_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_q[15:0]}};
      end
      default: ;
    endcase
  end

  // EX/MEM is frozen while mem_req is high, so these stay stable for the access.
  assign mem_addr  = {alu_q[ADDR_W-1:2], 2'b00};
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_we    = mem_req & memwrite_q;
  assign mem_wdata = wdata;

  load_align u_load_align (
    .offset   (off),
    .size     (size_q),
    .sign_ext (signed_q),
    .rdata    (mem_rdata),
    .result   (load_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aluResultOut  <= '0;
      readDataOut   <= '0;
      writeRegOut   <= '0;
      regWriteOut   <= 1'b0;
      memToRegOut   <= 1'b0;
      excMisaligned <= 1'b0;
    end else if (!stall) begin
      aluResultOut  <= alu_q;
      readDataOut   <= load_ext;
      writeRegOut   <= wreg_q;
      regWriteOut   <= regwrite_q & ~trap;
      memToRegOut   <= memtoreg_q;
      excMisaligned <= trap;
    end else begin
      regWriteOut   <= 1'b0;
      memToRegOut   <= 1'b0;
      excMisaligned <= 1'b0;
    end
  end

  assign wbData = memToRegOut ? readDataOut : aluResultOut;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [31:0] aluResult, reg2Out;
  logic [4:0]  muxRegDstOut;
  logic        regWrite, memToReg, memRead, memWrite, memSigned;
  logic [1:0]  memSize;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;
  logic [31:0] wbData, aluResultOut, readDataOut;
  logic [4:0]  writeRegOut;
  logic        regWriteOut, memToRegOut, excMisaligned;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .aluResult(aluResult), .reg2Out(reg2Out), .muxRegDstOut(muxRegDstOut),
    .regWrite(regWrite), .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite),
    .memSize(memSize), .memSigned(memSigned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .wbData(wbData), .aluResultOut(aluResultOut),
    .readDataOut(readDataOut), .writeRegOut(writeRegOut), .regWriteOut(regWriteOut),
    .memToRegOut(memToRegOut), .excMisaligned(excMisaligned)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
    logic [31:0] wb;
    logic [31:0] rdd;
    logic        chk_rd;
  } wb_exp_t;

  mem_exp_t    mem_q[$];
  wb_exp_t     wb_q[$];
  mem_exp_t    me;
  wb_exp_t     we_e;
  int          tests = 0;
  int          fails = 0;
  int          waits = 0;
  int          wait_cnt = 0;
  logic [31:0] rdata_cfg = 32'h0;
  logic        late_ack = 1'b0;
  logic        req_seen;
  int          nstall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic [31:0] a, input logic [3:0] b, input logic w, input logic [31:0] d);
    mem_q.push_back('{addr: a, be: b, we: w, wdata: d});
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic rw, input logic exc,
                         input logic [31:0] wb, input logic [31:0] rdd, input logic chk_rd);
    wb_q.push_back('{rd: rd, rw: rw, exc: exc, wb: wb, rdd: rdd, chk_rd: chk_rd});
  endtask

  // Data-memory model: acks after `waits` request cycles, or unconditionally when late_ack.
  always @(negedge clk) begin
    if (late_ack) begin
      mem_ack <= 1'b1;
    end else if (mem_ack) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (mem_req) begin
      if (wait_cnt >= waits) begin
        mem_ack   <= 1'b1;
        mem_rdata <= rdata_cfg;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Monitor: memory handshakes and write-back retirements against the scoreboard.
  always @(negedge clk) begin
    #4;
    if (mem_req && mem_ack) begin
      if (mem_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_mem_access: got addr 0x%08h be %b, expected none", mem_addr, mem_be);
      end else begin
        me = mem_q.pop_front();
        chk("mem_addr", mem_addr, me.addr);
        chk("mem_be", 32'(mem_be), 32'(me.be));
        chk("mem_we", 32'(mem_we), 32'(me.we));
        if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
      end
    end
    if (regWriteOut || excMisaligned) begin
      if (wb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_writeback: got rd %0d data 0x%08h, expected none", writeRegOut, wbData);
      end else begin
        we_e = wb_q.pop_front();
        chk("writeRegOut", 32'(writeRegOut), 32'(we_e.rd));
        chk("regWriteOut", 32'(regWriteOut), 32'(we_e.rw));
        chk("excMisaligned", 32'(excMisaligned), 32'(we_e.exc));
        if (!we_e.exc) chk("wbData", wbData, we_e.wb);
        if (we_e.chk_rd) chk("readDataOut", readDataOut, we_e.rdd);
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [31:0] st, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic mr, input logic mw,
                       input logic [1:0] sz, input logic sg, input logic fl,
                       input int nwait, input logic [31:0] rdat, input logic fl_stall,
                       input bit drain, output logic seen, output int ns);
    bit ok;
    waits = nwait;
    rdata_cfg = rdat;
    aluResult = addr; reg2Out = st; muxRegDstOut = rd;
    regWrite = rw; memToReg = m2r; memRead = mr; memWrite = mw;
    memSize = sz; memSigned = sg; flush = fl;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #4;
      ok = !stall;
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL capture_timeout: got stall held, expected capture");
    end
    aluResult = 32'h0; reg2Out = 32'h0; muxRegDstOut = 5'd0;
    regWrite = 1'b0; memToReg = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    memSize = SIZE_BYTE; memSigned = 1'b0; flush = fl_stall;
    @(negedge clk); #4;
    seen = mem_req;
    ns = 0;
    if (drain) begin
      ok = !stall;
      for (int i = 0; i < 50 && !ok; i++) begin
        ns++;
        @(posedge clk); #1;
        @(negedge clk); #4;
        ok = !stall;
      end
      if (!ok) begin
        tests++; fails++;
        $display("FAIL drain_timeout: got stall held, expected ack");
      end
      @(posedge clk); #1;
      flush = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    aluResult = 32'h0; reg2Out = 32'h0; muxRegDstOut = 5'd0;
    regWrite = 1'b0; memToReg = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    memSize = SIZE_BYTE; memSigned = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #4;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_regWriteOut", 32'(regWriteOut), 32'h0);
    chk("rst_excMisaligned", 32'(excMisaligned), 32'h0);
    chk("rst_wbData", wbData, 32'h0);
    chk("rst_readDataOut", readDataOut, 32'h0);
    chk("rst_aluResultOut", aluResultOut, 32'h0);
    chk("rst_writeRegOut", 32'(writeRegOut), 32'h0);
    @(posedge clk); #1;

    // zero-wait word load
    push_mem(32'h10, 4'b1111, 1'b0, 32'h0);
    push_wb(5'd3, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    issue(32'h10, 32'h0, 5'd3, 1, 1, 1, 0, SIZE_WORD, 0, 0, 0, 32'hDEADBEEF, 0, 1, req_seen, nstall);
    chk("zw_req_seen", 32'(req_seen), 32'h1);
    chk("zw_stall_cycles", 32'(nstall), 32'h0);

    // signed byte load, two wait cycles
    push_mem(32'h10, 4'b1000, 1'b0, 32'h0);
    push_wb(5'd5, 1'b1, 1'b0, 32'hFFFFFF80, 32'hFFFFFF80, 1'b1);
    issue(32'h13, 32'h0, 5'd5, 1, 1, 1, 0, SIZE_BYTE, 1, 0, 2, 32'h80123456, 0, 1, req_seen, nstall);
    chk("sb_stall_cycles", 32'(nstall), 32'h2);

    // unsigned upper halfword load, one wait cycle
    push_mem(32'h14, 4'b1100, 1'b0, 32'h0);
    push_wb(5'd6, 1'b1, 1'b0, 32'h00009ABC, 32'h00009ABC, 1'b1);
    issue(32'h16, 32'h0, 5'd6, 1, 1, 1, 0, SIZE_HALF, 0, 0, 1, 32'h9ABC1234, 0, 1, req_seen, nstall);
    chk("uh_stall_cycles", 32'(nstall), 32'h1);

    // halfword store to upper lanes
    push_mem(32'h20, 4'b1100, 1'b1, 32'hABCDABCD);
    issue(32'h22, 32'h0000ABCD, 5'd0, 0, 0, 0, 1, SIZE_HALF, 0, 0, 0, 32'h0, 0, 1, req_seen, nstall);
    chk("sh_stall_cycles", 32'(nstall), 32'h0);

    // byte store to lane 1, three wait cycles
    push_mem(32'h30, 4'b0010, 1'b1, 32'h5A5A5A5A);
    issue(32'h31, 32'h1234565A, 5'd0, 0, 0, 0, 1, SIZE_BYTE, 0, 0, 3, 32'h0, 0, 1, req_seen, nstall);
    chk("sb_store_stall_cycles", 32'(nstall), 32'h3);

    // ALU-only instruction passes through
    push_wb(5'd9, 1'b1, 1'b0, 32'h12345678, 32'h0, 1'b0);
    issue(32'h12345678, 32'h0, 5'd9, 1, 0, 0, 0, SIZE_WORD, 0, 0, 0, 32'h0, 0, 1, req_seen, nstall);
    chk("alu_req_seen", 32'(req_seen), 32'h0);

    // load flushed at capture becomes a bubble
    issue(32'h40, 32'h0, 5'd4, 1, 1, 1, 0, SIZE_WORD, 0, 1, 0, 32'h55555555, 0, 1, req_seen, nstall);
    chk("flush_req_seen", 32'(req_seen), 32'h0);
    chk("flush_stall_cycles", 32'(nstall), 32'h0);

    // flush raised while stalled must not disturb the held load
    push_mem(32'h44, 4'b1111, 1'b0, 32'h0);
    push_wb(5'd10, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1);
    issue(32'h44, 32'h0, 5'd10, 1, 1, 1, 0, SIZE_WORD, 0, 0, 2, 32'hCAFEF00D, 1, 1, req_seen, nstall);
    chk("flush_stall_cycles_held", 32'(nstall), 32'h2);

    // misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    push_wb(5'd7, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    issue(32'h21, 32'h0, 5'd7, 1, 1, 1, 0, SIZE_WORD, 0, 0, 0, 32'h11223344, 0, 1, req_seen, nstall);
    chk("mis_req_seen", 32'(req_seen), 32'h0);
`else
    push_mem(32'h20, 4'b1111, 1'b0, 32'h0);
    push_wb(5'd7, 1'b1, 1'b0, 32'h11223344, 32'h11223344, 1'b1);
    issue(32'h21, 32'h0, 5'd7, 1, 1, 1, 0, SIZE_WORD, 0, 0, 0, 32'h11223344, 0, 1, req_seen, nstall);
    chk("mis_req_seen", 32'(req_seen), 32'h1);
`endif
    chk("mis_stall_cycles", 32'(nstall), 32'h0);

    // reset while waiting abandons the access; a late ack is ignored
    issue(32'h50, 32'h0, 5'd11, 1, 1, 1, 0, SIZE_WORD, 0, 0, 100, 32'h77777777, 0, 0, req_seen, nstall);
    chk("rw_req_seen", 32'(req_seen), 32'h1);
    chk("rw_stall_before", 32'(stall), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #4;
    chk("rw_mem_req", 32'(mem_req), 32'h0);
    chk("rw_stall", 32'(stall), 32'h0);
    chk("rw_mem_be", 32'(mem_be), 32'h0);
    chk("rw_mem_we", 32'(mem_we), 32'h0);
    chk("rw_mem_addr", mem_addr, 32'h0);
    chk("rw_regWriteOut", 32'(regWriteOut), 32'h0);
    chk("rw_wbData", wbData, 32'h0);
    chk("rw_aluResultOut", aluResultOut, 32'h0);
    chk("rw_writeRegOut", 32'(writeRegOut), 32'h0);
    late_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4;
      chk("late_ack_mem_req", 32'(mem_req), 32'h0);
      chk("late_ack_stall", 32'(stall), 32'h0);
    end
    @(posedge clk); #1;
    late_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // recovery: signed halfword load after the abandoned access
    push_mem(32'h08, 4'b1100, 1'b0, 32'h0);
    push_wb(5'd12, 1'b1, 1'b0, 32'hFFFF8001, 32'hFFFF8001, 1'b1);
    issue(32'h0A, 32'h0, 5'd12, 1, 1, 1, 0, SIZE_HALF, 1, 0, 0, 32'h80017FFF, 0, 1, req_seen, nstall);
    chk("rec_stall_cycles", 32'(nstall), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("mem_queue_drained", 32'(mem_q.size()), 32'h0);
    chk("wb_queue_drained", 32'(wb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
